// File: rtl/matrix_win_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_win_ctrl
//
// Purpose:
//   Timing controller for a 7x7 matrix (window) datapath fed by a
//   vsync/href/clken video stream. It tracks the column and row of every
//   accepted pixel beat, counts how many complete lines are buffered in
//   the six line buffers, and flags beats whose 7x7 window lies fully
//   inside the image. Window flags are delayed so they line up with the
//   output beat of the matrix datapath. Line and frame length errors are
//   latched per frame.
//
// Parameters:
//   IMG_HDISP   active pixels per line
//   IMG_VDISP   active lines per frame
//   ALIGN_DLY   cycles from input beat to matrix datapath output beat
//
// Ports:
//   clk              single clock, rising edge
//   rst_n            asynchronous active-low reset
//   per_frame_vsync  frame valid (high during the frame)
//   per_frame_href   line valid
//   per_frame_clken  pixel beat strobe
//   col_cnt          accepted beats in the current line (saturating)
//   row_cnt          completed lines in the current frame (saturating)
//   line_fill        complete lines held in the line buffers, max 6
//   win_valid        window fully inside the image, datapath aligned
//   win_ccol         window centre column (0 when win_valid is low)
//   win_crow         window centre row    (0 when win_valid is low)
//   frame_start      one-cycle pulse when a frame is entered
//   frame_done       one-cycle pulse when a frame ends
//   line_len_err     sticky: a line ended with the wrong beat count
//   frame_len_err    sticky: a frame ended with the wrong line count
// ---------------------------------------------------------------------------
module matrix_win_ctrl #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480,
  parameter int         ALIGN_DLY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  output logic [9:0] col_cnt,
  output logic [9:0] row_cnt,
  output logic [2:0] line_fill,
  output logic       win_valid,
  output logic [9:0] win_ccol,
  output logic [9:0] win_crow,
  output logic       frame_start,
  output logic       frame_done,
  output logic       line_len_err,
  output logic       frame_len_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;
  localparam logic [1:0] ST_LINE  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic       in_frame;
  logic       beat;
  logic       line_end;
  logic       frame_end;
  logic       frame_go;
  logic       in_win;
  logic [9:0] row_inc;
  logic [9:0] row_final;
  logic       row_ovf_final;

  // Overflow markers: the counters saturate, so a line or frame that runs
  // past its nominal length would otherwise be indistinguishable from an
  // exact one.
  logic       col_ovf;
  logic       row_ovf;

  // Alignment shift register; the last stage drives the window outputs.
  logic [ALIGN_DLY:0] pipe_v;
  logic [9:0]         pipe_c [0:ALIGN_DLY];
  logic [9:0]         pipe_r [0:ALIGN_DLY];

  // Event decode. A beat needs vsync still high so that a beat coinciding
  // with the frame falling edge is not counted into a finished frame.
  // Line end in LINE is either href dropping or vsync dropping under it.
  always_comb begin
    in_frame  = (state == ST_FRAME) || (state == ST_LINE);
    beat      = in_frame && per_frame_vsync && per_frame_href && per_frame_clken;
    line_end  = (state == ST_LINE) && (!per_frame_href || !per_frame_vsync);
    frame_end = in_frame && !per_frame_vsync;
    frame_go  = (state == ST_ARMED) && per_frame_vsync;

    row_inc   = (row_cnt >= IMG_VDISP) ? row_cnt : row_cnt + 10'd1;
    row_final = line_end ? row_inc : row_cnt;
    row_ovf_final = row_ovf || (line_end && (row_cnt >= IMG_VDISP));

    in_win = beat &&
             (col_cnt >= 10'd6) && (row_cnt >= 10'd6) &&
             (col_cnt < IMG_HDISP) && (row_cnt < IMG_VDISP);
  end

  // Next-state logic. IDLE only leaves once vsync has been seen low, so a
  // frame already in progress at reset release is skipped entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!per_frame_vsync) state_nxt = ST_ARMED;
      ST_ARMED: if (per_frame_vsync)  state_nxt = ST_FRAME;
      ST_FRAME: begin
        if (!per_frame_vsync)    state_nxt = ST_ARMED;
        else if (per_frame_href) state_nxt = ST_LINE;
      end
      ST_LINE: begin
        if (!per_frame_vsync)     state_nxt = ST_ARMED;
        else if (!per_frame_href) state_nxt = ST_FRAME;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Position counters, line buffer fill level, pulses and sticky errors.
  // A vsync fall inside a line performs the line-end update and the
  // frame-end check in the same cycle, using the post-increment row count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt       <= '0;
      row_cnt       <= '0;
      line_fill     <= '0;
      col_ovf       <= 1'b0;
      row_ovf       <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      line_len_err  <= 1'b0;
      frame_len_err <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (frame_go) begin
        frame_start   <= 1'b1;
        col_cnt       <= '0;
        row_cnt       <= '0;
        line_fill     <= '0;
        col_ovf       <= 1'b0;
        row_ovf       <= 1'b0;
        line_len_err  <= 1'b0;
        frame_len_err <= 1'b0;
      end else begin
        if (beat) begin
          if (col_cnt < IMG_HDISP) col_cnt <= col_cnt + 10'd1;
          else                     col_ovf <= 1'b1;
        end
        if (line_end) begin
          col_cnt <= '0;
          col_ovf <= 1'b0;
          row_cnt <= row_inc;
          if (row_cnt >= IMG_VDISP) row_ovf <= 1'b1;
          if (line_fill < 3'd6) line_fill <= line_fill + 3'd1;
          if ((col_cnt != IMG_HDISP) || col_ovf) line_len_err <= 1'b1;
        end
        if (frame_end) begin
          frame_done <= 1'b1;
          if ((row_final != IMG_VDISP) || row_ovf_final) frame_len_err <= 1'b1;
        end
      end
    end
  end

  // Window alignment pipeline. Centre coordinates are captured at the beat
  // and forced to zero for non-window beats so the outputs read 0 whenever
  // win_valid is low. It keeps shifting across vsync edges so beats in
  // flight at frame end still emerge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i <= ALIGN_DLY; i++) begin
        pipe_c[i] <= '0;
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_v[0] <= in_win;
      pipe_c[0] <= in_win ? (col_cnt - 10'd3) : 10'd0;
      pipe_r[0] <= in_win ? (row_cnt - 10'd3) : 10'd0;
      for (int i = 1; i <= ALIGN_DLY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_c[i] <= pipe_c[i-1];
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign win_valid = pipe_v[ALIGN_DLY];
  assign win_ccol  = pipe_c[ALIGN_DLY];
  assign win_crow  = pipe_r[ALIGN_DLY];

endmodule

// File: tb/tb_matrix_win_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matrix_win_ctrl
//
// Self-checking bench for matrix_win_ctrl at 16x12 with a 3-cycle datapath
// delay. The stimulus driver pushes each expected window output (centre
// column, centre row, cycle it must appear) into a queue as it issues the
// beat; an independent monitor pops and compares whenever win_valid is high.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matrix_win_ctrl;

  localparam logic [9:0] H   = 10'd16;
  localparam logic [9:0] V   = 10'd12;
  localparam int         DLY = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href  = 1'b0;
  logic       clken = 1'b0;
  logic [9:0] col_cnt;
  logic [9:0] row_cnt;
  logic [2:0] line_fill;
  logic       win_valid;
  logic [9:0] win_ccol;
  logic [9:0] win_crow;
  logic       frame_start;
  logic       frame_done;
  logic       line_len_err;
  logic       frame_len_err;

  matrix_win_ctrl #(
    .IMG_HDISP(H),
    .IMG_VDISP(V),
    .ALIGN_DLY(DLY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .per_frame_vsync(vsync),
    .per_frame_href(href),
    .per_frame_clken(clken),
    .col_cnt(col_cnt),
    .row_cnt(row_cnt),
    .line_fill(line_fill),
    .win_valid(win_valid),
    .win_ccol(win_ccol),
    .win_crow(win_crow),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .line_len_err(line_len_err),
    .frame_len_err(frame_len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ccol;
    int crow;
    int due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int fs_seen  = 0;
  int fd_seen  = 0;
  int win_seen = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic h, input logic c);
    vsync = v;
    href  = h;
    clken = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_col"}, col_cnt, 0);
    checkOutput({tag, "_row"}, row_cnt, 0);
    checkOutput({tag, "_fill"}, line_fill, 0);
    checkOutput({tag, "_wv"}, win_valid, 0);
    checkOutput({tag, "_ccol"}, win_ccol, 0);
    checkOutput({tag, "_crow"}, win_crow, 0);
    checkOutput({tag, "_fs"}, frame_start, 0);
    checkOutput({tag, "_fd"}, frame_done, 0);
    checkOutput({tag, "_lerr"}, line_len_err, 0);
    checkOutput({tag, "_ferr"}, frame_len_err, 0);
  endtask

  // Monitor: counts pulses and compares every window output with the
  // oldest queued expectation, including the exact cycle it appears in.
  always @(negedge clk) begin
    if (frame_start) fs_seen++;
    if (frame_done)  fd_seen++;
    if (win_valid) begin
      win_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL win_unexpected: actual ccol=%0d crow=%0d, required no window", win_ccol, win_crow);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("win_ccol", win_ccol, mon_e.ccol);
        checkOutput("win_crow", win_crow, mon_e.crow);
        checkOutput("win_cycle", cyc, mon_e.due);
      end
    end else begin
      checkOutput("idle_ccol", win_ccol, 0);
      checkOutput("idle_crow", win_crow, 0);
    end
  end

  // One full frame: armed-state noise, frame start, nlines lines with
  // 4-cycle href gaps, then frame end and pipeline drain.
  task automatic runFrame(input int nlines, input int short_line, input bit gapped,
                          input bit fused_end, input bit exp_lerr, input bit exp_ferr);
    int  fs0;
    int  fd0;
    int  w0;
    int  nb;
    int  c;
    int  ph;
    int  rexp;
    bit  ce;
    bit  err;
    fs0 = fs_seen;
    fd0 = fd_seen;
    w0  = win_seen;
    err = 1'b0;

    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("armed_ignore_col", col_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("frame_start", frame_start, 1);
    checkOutput("start_row", row_cnt, 0);
    checkOutput("start_fill", line_fill, 0);
    checkOutput("start_lerr", line_len_err, 0);
    checkOutput("start_ferr", frame_len_err, 0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);

    for (int r = 0; r < nlines; r++) begin
      nb = (r == short_line) ? 15 : 16;
      c  = 0;
      ph = 0;
      while (c < nb) begin
        ce = gapped ? ((ph % 2) == 0) : 1'b1;
        if (ce) begin
          if (r >= 6 && r < 12 && c >= 6 && c < 16)
            sb.push_back('{ccol: c - 3, crow: r - 3, due: cyc + DLY + 1});
          c++;
        end
        applyStimulus(1'b1, 1'b1, ce);
        ph++;
      end
      if (r == short_line) err = 1'b1;
      rexp = (r + 1 > 12) ? 12 : r + 1;
      if (r == nlines - 1 && fused_end) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("fused_row", row_cnt, 12);
        checkOutput("fused_done", frame_done, 1);
        checkOutput("fused_lerr", line_len_err, 0);
      end else begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("line_row", row_cnt, rexp);
        checkOutput("line_col", col_cnt, 0);
        checkOutput("line_fill", line_fill, (r + 1 > 6) ? 6 : r + 1);
        checkOutput("line_lerr", line_len_err, err);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      end
    end

    if (!fused_end) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("frame_done", frame_done, 1);
    end
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0);

    checkOutput("frame_start_count", fs_seen - fs0, 1);
    checkOutput("frame_done_count", fd_seen - fd0, 1);
    checkOutput("win_count", win_seen - w0, 60);
    checkOutput("sb_empty", sb.size(), 0);
    checkOutput("end_row", row_cnt, 12);
    checkOutput("end_lerr", line_len_err, exp_lerr);
    checkOutput("end_ferr", frame_len_err, exp_ferr);
  endtask

  // Abort a frame at row 5 with reset held while vsync stays high.
  task automatic runResetMidFrame();
    int fs0;
    int fd0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      repeat (16) applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (4)  applyStimulus(1'b1, 1'b0, 1'b0);
    end
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("pre_reset_row", row_cnt, 5);
    fs0 = fs_seen;
    fd0 = fd_seen;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);
    checkAllZero("rst_hold");
    rst_n = 1'b1;
    repeat (5) applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_no_start", fs_seen - fs0, 0);
    checkOutput("post_rst_no_done", fd_seen - fd0, 0);
    checkOutput("post_rst_col", col_cnt, 0);
    checkOutput("post_rst_row", row_cnt, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rearm_start", frame_start, 1);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rearm_done", frame_done, 1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] matrix_win_ctrl bench start");
    rst_n = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] nominal frame");
    runFrame(12, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] gapped clken frame");
    runFrame(12, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("[TB] short line frame");
    runFrame(12, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("[TB] long frame");
    runFrame(14, -1, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] vsync and href fall together");
    runFrame(12, -1, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("[TB] reset mid-frame");
    runResetMidFrame();

    checkOutput("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_win_ctrl.md
MATRIX_WIN_CTRL -- requirements
Module: matrix_win_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_HDISP, default 10'd640, meaning active pixels per line.
REQ-002 The block SHALL have parameter IMG_VDISP, default 10'd480, meaning active lines per frame.
REQ-003 The block SHALL have parameter ALIGN_DLY, default 3, meaning cycles from input beat to the matrix datapath output beat.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 per_frame_vsync  input  1  frame valid, high during the frame.
REQ-007 per_frame_href  input  1  line valid.
REQ-008 per_frame_clken  input  1  pixel beat strobe.
REQ-009 col_cnt  output  10  accepted beats in the current line.
REQ-010 row_cnt  output  10  completed lines in the current frame.
REQ-011 line_fill  output  3  complete lines held in the 6 line buffers, saturating at 6.
REQ-012 win_valid  output  1  7x7 window fully inside the image, aligned to the datapath output.
REQ-013 win_ccol / win_crow  output  10 each  window centre coordinates, aligned with win_valid.
REQ-014 frame_start / frame_done  output  1 each  single-cycle pulses.
REQ-015 line_len_err / frame_len_err  output  1 each  sticky error flags.

Function
REQ-016 The FSM SHALL have states IDLE, ARMED, FRAME and LINE.
REQ-017 IDLE->ARMED SHALL occur when vsync is sampled low; this prevents a partial frame from being processed after reset.
REQ-018 ARMED->FRAME SHALL occur on vsync sampled high.
REQ-019 On ARMED->FRAME, the block SHALL pulse frame_start and clear col_cnt, row_cnt, line_fill and both error flags.
REQ-020 FRAME->LINE SHALL occur on href high; LINE->FRAME SHALL occur on href low (line end).
REQ-021 FRAME or LINE SHALL go to ARMED on vsync low, pulsing frame_done for one cycle.
REQ-022 A beat SHALL be defined as href && clken sampled in LINE, or in the cycle FRAME->LINE.
REQ-023 Each beat SHALL increment col_cnt, which saturates at IMG_HDISP.
REQ-024 At line end, col_cnt SHALL clear.
REQ-025 At line end, row_cnt SHALL increment, saturating at IMG_VDISP.
REQ-026 At line end, line_fill SHALL increment, saturating at 6.
REQ-027 At line end, line_len_err SHALL set if col_cnt != IMG_HDISP.
REQ-028 vsync falling while in LINE SHALL be processed as line end and frame end in the same cycle: row_cnt update, line check and frame_done all occur.
REQ-029 At frame end, frame_len_err SHALL set if the final row_cnt != IMG_VDISP.
REQ-030 href or clken while in IDLE or ARMED SHALL be ignored.
REQ-031 A beat at column c and row r (pre-increment col_cnt and row_cnt) SHALL be in-window when both of the following hold:
- r >= 6 and c >= 6;
- c < IMG_HDISP and r < IMG_VDISP.
REQ-032 For an in-window beat, win_valid SHALL be high exactly ALIGN_DLY+1 cycles after the beat cycle.
REQ-033 win_ccol SHALL equal c-3 and win_crow SHALL equal r-3 in the win_valid cycle; both SHALL read 0 when win_valid is low.
REQ-034 The alignment pipeline SHALL be a shift register that keeps running when vsync falls; in-flight beats still emerge.
REQ-035 All outputs SHALL be registered; counters SHALL update one cycle after the sampled event.
REQ-036 Error flags SHALL hold until the next frame_start or reset.

Reset
REQ-037 While rst_n is low, state SHALL be IDLE.
REQ-038 While rst_n is low, all counters, flags, pulses, pipeline stages, win_valid, win_ccol and win_crow SHALL be 0.
REQ-039 Reset asserted mid-frame SHALL abort the frame with no frame_done.
REQ-040 After reset release with vsync high, no frame_start SHALL occur until vsync has been low for at least one cycle.

Verification (IMG_HDISP=16, IMG_VDISP=12, ALIGN_DLY=3)
REQ-041 Nominal frame:
- stimulus: full 12x16 frame, clken=1, 4-cycle href gaps;
- response: frame_start pulse once; 60 win_valid cycles (6 rows x 10 cols); first win_valid at (ccol 3, crow 3) 4 cycles after the beat at r=6, c=6; frame_done once; both errors 0.
REQ-042 Gapped clken:
- stimulus: clken toggling 1010 during the frame;
- response: the same 60 window outputs in the same order, each 4 cycles after its beat.
REQ-043 Short line:
- stimulus: line 2 carries 15 beats;
- response: line_len_err=1 from line-end+1 until the next frame_start; row_cnt still increments.
REQ-044 Long frame:
- stimulus: 14 lines;
- response: row_cnt stays at 12; no win_valid for rows 12-13; frame_len_err=1 after frame end.
REQ-045 vsync and href fall together:
- stimulus: vsync and href fall in the same cycle on line 12;
- response: row_cnt=12, frame_done=1 and line_len_err=0 in the same cycle.
REQ-046 Reset mid-frame:
- stimulus: rst_n low at row 5, released with vsync high;
- response: all outputs 0; no frame_start until a vsync low-then-high sequence.
